// File: rtl/uart_tx_queue_if.sv
`default_nettype none
// ============================================================================
// uart_tx_queue_if : byte write port plus UART transmit handshake bundle
// Revision 1.0
// ============================================================================
interface uart_tx_queue_if #(
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          flush;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          sent;
   logic          uart_transmit;
   logic [7:0]    uart_tx_byte;
   logic          uart_busy;

   // Environment side: system writer and the UART's busy flag
   modport master (
      output wr_en, wr_data, flush, uart_busy,
      input  full, empty, count, overflow, sent, uart_transmit, uart_tx_byte
   );

   // Queue side
   modport slave (
      input  wr_en, wr_data, flush, uart_busy,
      output full, empty, count, overflow, sent, uart_transmit, uart_tx_byte
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// uart_tx_queue : byte FIFO feeding a UART through a transmit/busy handshake
// Revision 1.0
// ============================================================================
module uart_tx_queue #(
   parameter int DEPTH = 16
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   uart_tx_queue_if.slave  bus
);
   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOAD      = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          sent_q, sent_d;
   logic          transmit_q, transmit_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic [7:0]    mem_q [DEPTH];

   logic          full;
   logic          empty;
   logic          wr_accept;
   logic          pop;

   assign full      = (count_q == FULL_COUNT);
   assign empty     = (count_q == '0);
   // flush wins over both a same-cycle write and a same-cycle pop
   assign wr_accept = bus.wr_en && !full && !bus.flush;
   assign pop       = (state_q == S_IDLE) && !empty && !bus.uart_busy && !bus.flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = bus.wr_en && full && !bus.flush;
      if (bus.flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)       rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (wr_accept && !pop)      count_d = count_q + CNT_ONE;
         else if (pop && !wr_accept) count_d = count_q - CNT_ONE;
      end
   end

   always_comb begin
      state_d   = state_q;
      sent_d    = 1'b0;
      tx_byte_d = tx_byte_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d   = S_LOAD;
               tx_byte_d = mem_q[rd_ptr_q];
            end
         end
         S_LOAD: begin
            if (bus.uart_busy) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!bus.uart_busy) begin
               state_d = S_IDLE;
               sent_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // transmit is released as soon as the UART reports busy, so it never re-arms
      transmit_d = (state_d == S_LOAD);
   end

   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         sent_q     <= 1'b0;
         transmit_q <= 1'b0;
         tx_byte_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         sent_q     <= sent_d;
         transmit_q <= transmit_d;
         tx_byte_q  <= tx_byte_d;
      end
   end

   assign bus.full          = full;
   assign bus.empty         = empty;
   assign bus.count         = count_q;
   assign bus.overflow      = overflow_q;
   assign bus.sent          = sent_q;
   assign bus.uart_transmit = transmit_q;
   assign bus.uart_tx_byte  = tx_byte_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_queue : directed/randomized bench with a behavioural UART and scoreboard
// Revision 1.0
// ============================================================================
module tb_uart_tx_queue;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

   uart_tx_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // Behavioural UART: accepts a byte when idle and transmit is high, then stays busy
   int         busy_cnt = 0;
   logic       busy_hold = 1'b0;
   int         len_lo = 1;
   int         len_hi = 6;
   logic [7:0] rx_q [$];
   logic [7:0] exp_q [$];

   assign bus.uart_busy = (busy_cnt != 0) || busy_hold;

   always @(posedge clk) begin
      if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end else if (bus.uart_transmit && !busy_hold) begin
         busy_cnt <= int'($urandom_range(len_hi, len_lo));
         rx_q.push_back(bus.uart_tx_byte);
      end
   end

   int sent_cnt = 0;
   int ovf_cnt = 0;
   always @(negedge clk) begin
      if (bus.sent)     sent_cnt <= sent_cnt + 1;
      if (bus.overflow) ovf_cnt  <= ovf_cnt + 1;
   end

   int sent_adj = 0;
   int chk_idx = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d, input bit expect_tx);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      if (expect_tx) exp_q.push_back(d);
   endtask

   task automatic wait_tx(input logic lvl, input string tag);
      int n = 0;
      while (bus.uart_transmit !== lvl && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_wait"}, 32'(n < 500), 32'd1);
   endtask

   // Wait for the scoreboard to catch up, then compare the received stream in order
   task automatic drain(input string tag);
      int n = 0;
      while (!(rx_q.size() == exp_q.size() && !bus.uart_busy && !bus.uart_transmit
               && bus.empty) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drain_timeout"}, 32'(n < 3000), 32'd1);
      repeat (6) @(negedge clk);
      check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = chk_idx; i < exp_q.size(); i++) begin
         if (i < rx_q.size()) check({tag, "_rx_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
      end
      chk_idx = exp_q.size();
      check({tag, "_sent_pulses"}, 32'(sent_cnt + sent_adj), 32'(rx_q.size()));
   endtask

   initial begin
      logic [7:0] d;
      int base_ovf;
      int written;
      int guard;

      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.flush   = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_transmit", 32'(bus.uart_transmit), 32'd0);
      check("rst_tx_byte",  32'(bus.uart_tx_byte),  32'h00);
      check("rst_count",    32'(bus.count),         32'd0);
      check("rst_empty",    32'(bus.empty),         32'd1);
      check("rst_full",     32'(bus.full),          32'd0);
      check("rst_sent",     32'(bus.sent),          32'd0);
      check("rst_overflow", 32'(bus.overflow),      32'd0);
      rst_n = 1'b1;

      // Single byte: transmit one cycle after the write, held for exactly two cycles
      len_lo = 2; len_hi = 8;
      push_byte(8'hA5, 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      check("single_empty_after_write", 32'(bus.empty), 32'd0);
      check("single_tx_not_yet",        32'(bus.uart_transmit), 32'd0);
      @(negedge clk);
      check("single_tx_rise",  32'(bus.uart_transmit), 32'd1);
      check("single_tx_byte",  32'(bus.uart_tx_byte),  32'hA5);
      check("single_count",    32'(bus.count),         32'd0);
      @(negedge clk);
      check("single_tx_hold",  32'(bus.uart_transmit), 32'd1);
      @(negedge clk);
      check("single_tx_fall",  32'(bus.uart_transmit), 32'd0);
      drain("single");
      check("single_empty_end", 32'(bus.empty), 32'd1);

      // Burst of 16 with the UART held busy so the queue fills
      len_lo = 1; len_hi = 5;
      base_ovf  = ovf_cnt;
      busy_hold = 1'b1;
      for (int i = 1; i <= 16; i++) push_byte(8'(i), 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      check("burst_full",  32'(bus.full),  32'd1);
      check("burst_count", 32'(bus.count), 32'd16);
      busy_hold = 1'b0;
      drain("burst");
      check("burst_no_overflow", 32'(ovf_cnt - base_ovf), 32'd0);

      // Overflow: 17th write while full is dropped
      base_ovf  = ovf_cnt;
      busy_hold = 1'b1;
      for (int i = 0; i < 17; i++) push_byte(8'($urandom), i < 16);
      @(negedge clk);
      bus.wr_en = 1'b0;
      check("ovf_pulse", 32'(bus.overflow), 32'd1);
      check("ovf_count", 32'(bus.count),    32'd16);
      @(negedge clk);
      check("ovf_pulse_end", 32'(bus.overflow), 32'd0);
      busy_hold = 1'b0;
      drain("ovf");
      check("ovf_pulses", 32'(ovf_cnt - base_ovf), 32'd1);

      // Push on the pop edge keeps count, then stream 40 bytes through wrapping pointers
      busy_hold = 1'b1;
      for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      check("pp_count_pre", 32'(bus.count), 32'd3);
      busy_hold = 1'b0;
      d = 8'($urandom);
      bus.wr_en = 1'b1; bus.wr_data = d; exp_q.push_back(d);
      @(negedge clk);
      bus.wr_en = 1'b0;
      check("pp_count_same", 32'(bus.count), 32'd3);
      check("pp_transmit",   32'(bus.uart_transmit), 32'd1);
      written = 4; guard = 0;
      while (written < 40 && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (!bus.full && $urandom_range(3, 0) != 0) begin
            d = 8'($urandom);
            bus.wr_en = 1'b1; bus.wr_data = d; exp_q.push_back(d);
            written++;
         end else begin
            bus.wr_en = 1'b0;
         end
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      check("pp_stream_done", 32'(written), 32'd40);
      drain("pushpop");

      // Flush during WAIT_DONE: in-flight byte completes, rest discarded
      len_lo = 12; len_hi = 12;
      busy_hold = 1'b1;
      for (int i = 0; i < 5; i++) push_byte(8'($urandom), i == 0);
      @(negedge clk);
      bus.wr_en = 1'b0;
      busy_hold = 1'b0;
      wait_tx(1'b1, "flush_rise");
      wait_tx(1'b0, "flush_fall");
      check("flush_busy", 32'(bus.uart_busy), 32'd1);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_count", 32'(bus.count), 32'd0);
      check("flush_empty", 32'(bus.empty), 32'd1);
      drain("flush");
      repeat (20) @(negedge clk);
      check("flush_no_more_tx", 32'(rx_q.size()), 32'(exp_q.size()));

      // Reset mid-frame: outputs clear at once, nothing issued while the UART is busy
      len_lo = 20; len_hi = 20;
      push_byte(8'($urandom), 1'b1);
      push_byte(8'($urandom), 1'b0);
      @(negedge clk);
      bus.wr_en = 1'b0;
      wait_tx(1'b1, "rst_rise");
      wait_tx(1'b0, "rst_fall");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_transmit", 32'(bus.uart_transmit), 32'd0);
      check("midrst_tx_byte",  32'(bus.uart_tx_byte),  32'h00);
      check("midrst_count",    32'(bus.count),         32'd0);
      check("midrst_empty",    32'(bus.empty),         32'd1);
      sent_adj++;
      @(negedge clk);
      rst_n = 1'b1;
      len_lo = 1; len_hi = 4;
      push_byte(8'h3C, 1'b1);
      @(negedge clk);
      bus.wr_en = 1'b0;
      guard = 0;
      while (bus.uart_busy && guard < 100) begin
         check("midrst_no_tx_while_busy", 32'(bus.uart_transmit), 32'd0);
         @(negedge clk);
         guard++;
      end
      check("midrst_busy_ends", 32'(guard < 100), 32'd1);
      drain("midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
